trigger_power_discriminator: RTL

- Sits directly downstream of the pre-trigger filter chain (LPF -> biquads -> AGC) and consumes its 40-bit AGC output: 8 signed 5-bit samples per aclk.
- Computes instantaneous power over a 16-sample sliding window and compares it against a programmable threshold.
- Emits a one-cycle trigger pulse with programmable holdoff.
- Maintains a gated trigger-rate scaler for threshold tuning.

---
 rtl/trigger_pkg.sv | 19 +
 rtl/power_sum8.sv | 55 +++++
 rtl/trigger_power_discriminator.sv | 139 +++++++++++++
 3 files changed

// File: rtl/trigger_pkg.sv
// Shared types and widths for the trigger power discriminator.
// Samples arrive as signed 5-bit values from the AGC output.
package trigger_pkg;

  localparam int NSAMP       = 8;
  localparam int SAMPLE_BITS = 5;
  localparam int SQ_BITS     = 9;   // (-16)^2 = 256
  localparam int SUM_BITS    = 12;  // 8 * 256 = 2048
  localparam int POWER_BITS  = 13;  // 2 * 2048 = 4096

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;
  typedef logic        [POWER_BITS-1:0]  power_t;

  typedef enum logic {
    ARMED   = 1'b0,
    HOLDOFF = 1'b1
  } state_t;

endpackage

// File: rtl/power_sum8.sv
// Squares the eight samples of one word and adds them.
// Stage 1 registers the squares, stage 2 registers their sum.
module power_sum8
  import trigger_pkg::*;
(
  input  logic                         aclk,
  input  logic                         reset_i,
  input  logic [NSAMP*SAMPLE_BITS-1:0] dat_i,
  output logic [SUM_BITS-1:0]          sum_o
);

  logic [SQ_BITS-1:0]  sq_reg [NSAMP];
  logic [SUM_BITS-1:0] sum_reg;
  logic [SUM_BITS-1:0] sum_next;

  genvar gi;
  generate
    for (gi = 0; gi < NSAMP; gi++) begin : g_square
      sample_t                       sample;
      logic signed [2*SAMPLE_BITS-1:0] sample_ext;
      logic signed [2*SAMPLE_BITS-1:0] prod;

      assign sample     = sample_t'(dat_i[gi*SAMPLE_BITS +: SAMPLE_BITS]);
      assign sample_ext = (2*SAMPLE_BITS)'(sample);
      // The product is never negative and never exceeds 256, so the low bits suffice.
      assign prod       = sample_ext * sample_ext;

      always_ff @(posedge aclk) begin
        if (reset_i) begin
          sq_reg[gi] <= '0;
        end else begin
          sq_reg[gi] <= prod[SQ_BITS-1:0];
        end
      end
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NSAMP; i++) begin
      sum_next = sum_next + SUM_BITS'(sq_reg[i]);
    end
  end

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      sum_reg <= '0;
    end else begin
      sum_reg <= sum_next;
    end
  end

  assign sum_o = sum_reg;

endmodule

// File: rtl/trigger_power_discriminator.sv
// Two-word power window, threshold trigger with holdoff, and a gated
// trigger-rate scaler.
module trigger_power_discriminator
  import trigger_pkg::*;
#(
  parameter int HOLDOFF_BITS  = 8,
  parameter int SCALER_PERIOD = 1000000,
  parameter int SCALER_WIDTH  = 16
) (
  input  logic                         aclk,
  input  logic                         reset_i,
  input  logic [NSAMP*SAMPLE_BITS-1:0] dat_i,
  input  logic                         enable_i,
  input  logic [POWER_BITS-1:0]        threshold_i,
  input  logic [HOLDOFF_BITS-1:0]      holdoff_i,
  output logic                         trig_o,
  output logic [POWER_BITS-1:0]        power_o,
  output logic [SCALER_WIDTH-1:0]      scaler_o,
  output logic                         scaler_valid_o
);

  localparam int GATE_BITS = (SCALER_PERIOD > 1) ? $clog2(SCALER_PERIOD) : 1;
  localparam logic [GATE_BITS-1:0]    GATE_LAST = GATE_BITS'(SCALER_PERIOD - 1);
  localparam logic [SCALER_WIDTH-1:0] CNT_MAX   = '1;

  // Window
  logic [SUM_BITS-1:0] s_cur;
  logic [SUM_BITS-1:0] s_prev_reg;
  power_t              window;
  power_t              power_reg;

  power_sum8 u_power_sum8 (
    .aclk    (aclk),
    .reset_i (reset_i),
    .dat_i   (dat_i),
    .sum_o   (s_cur)
  );

  assign window = POWER_BITS'(s_cur) + POWER_BITS'(s_prev_reg);

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      s_prev_reg <= '0;
      power_reg  <= '0;
    end else begin
      s_prev_reg <= s_cur;
      power_reg  <= window;
    end
  end

  // Trigger FSM
  state_t                  state_reg, state_next;
  logic [HOLDOFF_BITS-1:0] holdoff_cnt_reg, holdoff_cnt_next;
  logic                    trig_reg, trig_next;
  logic                    fire;

  assign fire = (power_reg > threshold_i);

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      state_reg       <= ARMED;
      holdoff_cnt_reg <= '0;
      trig_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      holdoff_cnt_reg <= holdoff_cnt_next;
      trig_reg        <= trig_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    holdoff_cnt_next = holdoff_cnt_reg;
    trig_next        = 1'b0;
    case (state_reg)
      ARMED: begin
        if (enable_i && fire) begin
          trig_next        = 1'b1;
          holdoff_cnt_next = holdoff_i;
          if (holdoff_i != '0) begin
            state_next = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        // Leaving on count 1 makes exactly holdoff_i cycles dead after the pulse.
        holdoff_cnt_next = holdoff_cnt_reg - 1'b1;
        if (holdoff_cnt_reg == HOLDOFF_BITS'(1)) begin
          state_next = ARMED;
        end
      end
      default: begin
        state_next = ARMED;
      end
    endcase
  end

  // Rate scaler
  logic [GATE_BITS-1:0]    gate_reg, gate_next;
  logic [SCALER_WIDTH-1:0] trig_cnt_reg, trig_cnt_next;
  logic [SCALER_WIDTH-1:0] scaler_reg, scaler_next;
  logic                    scaler_valid_reg, scaler_valid_next;
  logic [SCALER_WIDTH-1:0] cnt_inc;

  assign cnt_inc = (trig_cnt_reg == CNT_MAX) ? CNT_MAX : trig_cnt_reg + 1'b1;

  always_comb begin
    gate_next         = (gate_reg == GATE_LAST) ? '0 : gate_reg + 1'b1;
    trig_cnt_next     = trig_reg ? cnt_inc : trig_cnt_reg;
    scaler_next       = scaler_reg;
    scaler_valid_next = 1'b0;
    // A pulse on the terminal cycle still belongs to the gate that is closing.
    if (gate_reg == GATE_LAST) begin
      scaler_next       = trig_cnt_next;
      scaler_valid_next = 1'b1;
      trig_cnt_next     = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      gate_reg         <= '0;
      trig_cnt_reg     <= '0;
      scaler_reg       <= '0;
      scaler_valid_reg <= 1'b0;
    end else begin
      gate_reg         <= gate_next;
      trig_cnt_reg     <= trig_cnt_next;
      scaler_reg       <= scaler_next;
      scaler_valid_reg <= scaler_valid_next;
    end
  end

  assign trig_o         = trig_reg;
  assign power_o        = power_reg;
  assign scaler_o       = scaler_reg;
  assign scaler_valid_o = scaler_valid_reg;

endmodule
